// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl
// March C- sequencer for one single-port synchronous SRAM.
// It steers an external up/down address counter and issues the reads and
// writes for each march element. Read data is compared one cycle later, and
// the first failing address and element are recorded.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               begin a test (honoured in IDLE or DONE only)
//   cnt_d_in/ld/u_d/cen counter load value, load, direction (1 = up), enable
//   cnt_q               current counter value
//   mem_addr            memory address (= cnt_q)
//   mem_we/re/wdata     memory write strobe, read strobe, write data
//   mem_rdata           memory read data, valid the cycle after mem_re
//   busy, done          test in progress / test complete
//   fail                sticky mismatch flag
//   fail_addr/elem      address and element of the first mismatch
//
// state | meaning
// IDLE  | after reset, waiting for start
// LOAD  | load counter with element start address
// OP_R  | read current address
// OP_W  | write current address, step or finish element
// DRAIN | last pipelined compare
// DONE  | test complete, waiting for restart
module mbist_march_ctrl #(
    parameter int length = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [length-1:0] cnt_d_in,
    output logic              cnt_ld,
    output logic              cnt_u_d,
    output logic              cnt_cen,
    input  logic [length-1:0] cnt_q,
    output logic [length-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [length-1:0] fail_addr,
    output logic [2:0]        fail_elem
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        OP_R  = 3'd2,
        OP_W  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        elem_q, elem_d;
    logic              clear_flags;

    logic              cmp_valid_q;
    logic [DATA_W-1:0] cmp_exp_q;
    logic [length-1:0] cmp_addr_q;
    logic [2:0]        cmp_elem_q;

    logic              fail_q, fail_d;
    logic [length-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]        fail_elem_q, fail_elem_d;

    // Element decode
    logic elem_up, elem_has_rd, elem_has_wr, elem_rd_val, elem_wr_val;
    logic terminal;

    always_comb begin
        elem_up     = 1'b1;
        elem_has_rd = 1'b0;
        elem_has_wr = 1'b1;
        elem_rd_val = 1'b0;
        elem_wr_val = 1'b0;
        case (elem_q)
            3'd1: begin elem_has_rd = 1'b1; elem_rd_val = 1'b0; elem_wr_val = 1'b1; end
            3'd2: begin elem_has_rd = 1'b1; elem_rd_val = 1'b1; elem_wr_val = 1'b0; end
            3'd3: begin elem_up = 1'b0; elem_has_rd = 1'b1; elem_rd_val = 1'b0; elem_wr_val = 1'b1; end
            3'd4: begin elem_up = 1'b0; elem_has_rd = 1'b1; elem_rd_val = 1'b1; elem_wr_val = 1'b0; end
            3'd5: begin elem_has_rd = 1'b1; elem_has_wr = 1'b0; end
            default: ;
        endcase
    end

    // Last address of the element in its own direction
    assign terminal = elem_up ? (cnt_q == {length{1'b1}}) : (cnt_q == {length{1'b0}});

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            elem_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        clear_flags = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = LOAD;
                    elem_d      = 3'd0;
                    clear_flags = 1'b1;
                end
            end
            LOAD: state_d = elem_has_rd ? OP_R : OP_W;
            OP_R: begin
                if (elem_has_wr)   state_d = OP_W;
                else if (terminal) state_d = DRAIN;
                else               state_d = OP_R;
            end
            OP_W: begin
                if (terminal) begin
                    state_d = LOAD;
                    elem_d  = elem_q + 3'd1;
                end else begin
                    state_d = elem_has_rd ? OP_R : OP_W;
                end
            end
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        cnt_d_in  = '0;
        cnt_ld    = 1'b0;
        cnt_u_d   = 1'b0;
        cnt_cen   = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            LOAD: begin
                busy     = 1'b1;
                cnt_ld   = 1'b1;
                cnt_cen  = 1'b1;
                cnt_u_d  = elem_up;
                cnt_d_in = elem_up ? {length{1'b0}} : {length{1'b1}};
            end
            OP_R: begin
                busy    = 1'b1;
                mem_re  = 1'b1;
                cnt_u_d = elem_up;
                // Read-only element steps straight from read to read
                cnt_cen = !elem_has_wr && !terminal;
            end
            OP_W: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = {DATA_W{elem_wr_val}};
                cnt_u_d   = elem_up;
                cnt_cen   = !terminal;
            end
            DRAIN: busy = 1'b1;
            DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Compare against the read issued in the previous cycle
    always_comb begin
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        if (clear_flags) begin
            fail_d      = 1'b0;
            fail_addr_d = '0;
            fail_elem_d = 3'd0;
        end else if (cmp_valid_q && (mem_rdata != cmp_exp_q)) begin
            fail_d = 1'b1;
            if (!fail_q) begin
                fail_addr_d = cmp_addr_q;
                fail_elem_d = cmp_elem_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_valid_q <= 1'b0;
            cmp_exp_q   <= '0;
            cmp_addr_q  <= '0;
            cmp_elem_q  <= 3'd0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= 3'd0;
        end else begin
            cmp_valid_q <= (state_q == OP_R);
            if (state_q == OP_R) begin
                cmp_exp_q  <= {DATA_W{elem_rd_val}};
                cmp_addr_q <= cnt_q;
                cmp_elem_q <= elem_q;
            end
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
        end
    end

    assign mem_addr  = cnt_q;
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
module tb_mbist_march_ctrl;

    localparam int L = 2;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [L-1:0] cnt_d_in;
    logic         cnt_ld, cnt_u_d, cnt_cen;
    logic [L-1:0] cnt_q = '0;
    logic [L-1:0] mem_addr;
    logic         mem_we, mem_re;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata = '0;
    logic         busy, done, fail;
    logic [L-1:0] fail_addr;
    logic [2:0]   fail_elem;

    logic [W-1:0] mem [4];
    logic         fault_en = 1'b0;

    int n_asserts = 0;
    int n_fail    = 0;

    mbist_march_ctrl #(.length(L), .DATA_W(W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cnt_d_in(cnt_d_in), .cnt_ld(cnt_ld), .cnt_u_d(cnt_u_d), .cnt_cen(cnt_cen),
        .cnt_q(cnt_q), .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .done(done),
        .fail(fail), .fail_addr(fail_addr), .fail_elem(fail_elem)
    );

    always #5 clk = ~clk;

    // Up/down counter: load has priority when enabled
    always @(posedge clk) begin
        if (cnt_cen) begin
            if (cnt_ld)       cnt_q <= cnt_d_in;
            else if (cnt_u_d) cnt_q <= cnt_q + 1'b1;
            else              cnt_q <= cnt_q - 1'b1;
        end
    end

    // 1-cycle-read SRAM; optional stuck-at-0 on bit 3 of address 2
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= (fault_en && mem_addr == 2'd2) ? (mem_wdata & 8'hF7) : mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {9'd0, cnt_d_in, cnt_ld, cnt_u_d, cnt_cen, mem_we, mem_re, mem_wdata,
                busy, done, fail, fail_addr, fail_elem};
    endfunction

    // Starts a run and watches it until done (bounded)
    task automatic run_test(input bit pulse_busy, input bit check_dn,
                            output int done_cyc, output int nwr, output int nrd, output int overlap);
        logic [31:0] exp_addr;
        done_cyc = 0; nwr = 0; nrd = 0; overlap = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_fail_clr", {31'd0, fail}, 32'd0);
        for (int k = 1; k <= 100; k++) begin
            if (done) begin
                done_cyc = k - 1;
                break;
            end
            if (mem_we) nwr++;
            if (mem_re) nrd++;
            if (mem_we && mem_re) overlap++;
            if (pulse_busy) start = (k == 10);
            if (check_dn && k == 1) begin
                chk("el0_ld", {31'd0, cnt_ld}, 32'd1);
                chk("el0_din", {30'd0, cnt_d_in}, 32'd0);
                chk("el0_ud", {31'd0, cnt_u_d}, 32'd1);
            end
            if (check_dn && k == 24) begin
                chk("el3_ld", {31'd0, cnt_ld}, 32'd1);
                chk("el3_din", {30'd0, cnt_d_in}, 32'd3);
                chk("el3_ud", {31'd0, cnt_u_d}, 32'd0);
            end
            if (check_dn && k >= 25 && k <= 32) begin
                exp_addr = 32'(3 - (k - 25) / 2);
                chk("el3_addr", {30'd0, mem_addr}, exp_addr);
                if (((k - 25) % 2) == 0) begin
                    chk("el3_re", {30'd0, mem_re, mem_we}, 32'd2);
                end else begin
                    chk("el3_we", {30'd0, mem_re, mem_we}, 32'd1);
                    chk("el3_wdata", {24'd0, mem_wdata}, 32'hFF);
                end
            end
            tick();
        end
        start = 1'b0;
    endtask

    int dc, nw, nr, ov;

    initial begin
        rst = 1'b1;
        start = 1'b1;
        tick();
        tick();
        chk("rst_outs", all_outs(), 32'd0);
        rst = 1'b0;
        start = 1'b0;
        tick();
        chk("idle_outs", all_outs(), 32'd0);

        // Clean run with element 0/3 sequencing checks
        run_test(1'b0, 1'b1, dc, nw, nr, ov);
        chk("clean_done_cyc", dc, 32'd47);
        chk("clean_fail", {31'd0, fail}, 32'd0);
        chk("clean_writes", nw, 32'd20);
        chk("clean_reads", nr, 32'd20);
        chk("clean_overlap", ov, 32'd0);
        for (int a = 0; a < 4; a++) chk("final_mem", {24'd0, mem[a]}, 32'h00);

        // Stuck-at-0 fault
        fault_en = 1'b1;
        run_test(1'b0, 1'b0, dc, nw, nr, ov);
        chk("fault_done_cyc", dc, 32'd47);
        chk("fault_fail", {31'd0, fail}, 32'd1);
        chk("fault_addr", {30'd0, fail_addr}, 32'd2);
        chk("fault_elem", {29'd0, fail_elem}, 32'd2);

        // Restart from DONE after a failed run
        fault_en = 1'b0;
        run_test(1'b0, 1'b0, dc, nw, nr, ov);
        chk("rerun_done_cyc", dc, 32'd47);
        chk("rerun_fail", {31'd0, fail}, 32'd0);

        // Reset mid-run, with the fault active so a compare is pending
        fault_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        tick();
        chk("midrst_outs", all_outs(), 32'd0);
        rst = 1'b0;
        fault_en = 1'b0;
        tick();
        chk("midrst_idle", all_outs(), 32'd0);
        run_test(1'b0, 1'b0, dc, nw, nr, ov);
        chk("midrst_done_cyc", dc, 32'd47);
        chk("midrst_fail", {31'd0, fail}, 32'd0);

        // start while busy is ignored
        run_test(1'b1, 1'b0, dc, nw, nr, ov);
        chk("busy_start_done_cyc", dc, 32'd47);
        chk("busy_start_writes", nw, 32'd20);
        tick();
        chk("busy_start_stays_done", {30'd0, busy, done}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
